cpu_irq_dispatcher: RTL and testbench

//  Interrupt arbiter and dispatch sequencer for the SM83 core.
//  - Selects the highest-priority pending interrupt (IE & IF; bit0 VBlank highest).
//  - Runs the 5-M-cycle dispatch: idle, SP--, push PCH, push PCL, jump to vector.
//  - Drives stack writes, SP decrement, PC load, IME clear and IF acknowledge

---
 rtl/cpu_types_pkg.sv | 34 +++
 rtl/cpu_irq_prio_enc.sv | 22 ++
 rtl/cpu_irq_dispatcher.sv | 108 ++++++++++
 tb/tb_cpu_irq_dispatcher.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared SM83 core types: bus phases, interrupt ids, dispatch states
package cpu_types_pkg;

    typedef enum logic [1:0] {
        T1 = 2'd0,
        T2 = 2'd1,
        T3 = 2'd2,
        T4 = 2'd3
    } t_phase_t;

    typedef enum logic [2:0] {
        IRQ_IDLE = 3'd0,
        IRQ_D1   = 3'd1,
        IRQ_D2   = 3'd2,
        IRQ_D3   = 3'd3,
        IRQ_D4   = 3'd4,
        IRQ_D5   = 3'd5
    } irq_state_t;

    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_STAT   = 1;
    localparam int IRQ_TIMER  = 2;
    localparam int IRQ_SERIAL = 3;
    localparam int IRQ_JOYPAD = 4;
    localparam int IRQ_COUNT  = 5;

    localparam logic [15:0] IRQ_VEC_BASE = 16'h0040;

    // Vectors are spaced 8 bytes apart starting at base.
    function automatic logic [15:0] irq_vector(input logic [15:0] base, input logic [7:0] idx);
        return base + {5'd0, idx, 3'd0};
    endfunction

endpackage

// File: rtl/cpu_irq_prio_enc.sv
// rtl/cpu_irq_prio_enc.sv - fixed-priority encoder, lowest set bit wins
module cpu_irq_prio_enc #(
    parameter int N     = 5,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     mask,
    output logic             valid,
    output logic [IDX_W-1:0] index
);

    always_comb begin
        valid = |mask;
        index = '0;
        // Scan downward so the last hit is the lowest index.
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/cpu_irq_dispatcher.sv
// rtl/cpu_irq_dispatcher.sv - SM83 interrupt arbiter and 5 M-cycle dispatch sequencer
module cpu_irq_dispatcher
    import cpu_types_pkg::*;
#(
    parameter logic [15:0] VEC_BASE = IRQ_VEC_BASE,
    parameter int          N_IRQ    = IRQ_COUNT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       t_phase,
    input  logic             instr_bound,
    input  logic             halted,
    input  logic             ime,
    input  logic [N_IRQ-1:0] ie,
    input  logic [N_IRQ-1:0] if_flags,
    input  logic [15:0]      pc,
    input  logic [15:0]      sp,
    output logic             busy,
    output logic             ime_clr,
    output logic             sp_dec,
    output logic             mem_wr,
    output logic [15:0]      mem_addr,
    output logic [7:0]       mem_wdata,
    output logic             pc_load,
    output logic [15:0]      pc_vec,
    output logic [N_IRQ-1:0] if_ack,
    output logic             wake
);

    localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    irq_state_t       state;
    logic [15:0]      vec_q;
    logic [N_IRQ-1:0] masked;
    logic             pending;
    logic             at_t4;
    logic             take;
    logic             sel_valid;
    logic [IDX_W-1:0] sel_idx;

    assign masked  = ie & if_flags;
    assign pending = |masked;
    assign at_t4   = (t_phase == T4);
    assign take    = (state == IRQ_IDLE) && at_t4 && ime && pending && (instr_bound || halted);

    cpu_irq_prio_enc #(
        .N     (N_IRQ),
        .IDX_W (IDX_W)
    ) u_prio (
        .mask  (masked),
        .valid (sel_valid),
        .index (sel_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IRQ_IDLE;
            vec_q <= 16'h0000;
        end else if (at_t4) begin
            case (state)
                IRQ_IDLE: if (take) state <= IRQ_D1;
                IRQ_D1:   state <= IRQ_D2;
                IRQ_D2:   state <= IRQ_D3;
                IRQ_D3:   state <= IRQ_D4;
                IRQ_D4: begin
                    // Selection is deferred to here: the PCH push may have rewritten IE.
                    state <= IRQ_D5;
                    vec_q <= sel_valid ? irq_vector(VEC_BASE, 8'(sel_idx)) : 16'h0000;
                end
                IRQ_D5:   state <= IRQ_IDLE;
                default:  state <= IRQ_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != IRQ_IDLE);
        ime_clr   = take && reset_n;
        sp_dec    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        pc_load   = 1'b0;
        pc_vec    = vec_q;
        if_ack    = '0;
        wake      = halted && pending && reset_n;
        case (state)
            IRQ_D2: sp_dec = at_t4;
            IRQ_D3: begin
                mem_wr    = 1'b1;
                mem_addr  = sp;
                mem_wdata = pc[15:8];
                sp_dec    = at_t4;
            end
            IRQ_D4: begin
                mem_wr    = 1'b1;
                mem_addr  = sp;
                mem_wdata = pc[7:0];
                if (at_t4 && sel_valid) begin
                    if_ack = {{(N_IRQ - 1){1'b0}}, 1'b1} << sel_idx;
                end
            end
            IRQ_D5: pc_load = at_t4;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_irq_dispatcher.sv
// tb/tb_cpu_irq_dispatcher.sv - self-checking bench for cpu_irq_dispatcher
module tb_cpu_irq_dispatcher;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  t_phase = 2'd0;
    logic        instr_bound = 1'b0;
    logic        halted = 1'b0;
    logic        ime = 1'b0;
    logic [4:0]  ie = 5'h00;
    logic [4:0]  if_flags = 5'h00;
    logic [15:0] pc = 16'h0000;
    logic [15:0] sp = 16'h0000;
    logic        busy, ime_clr, sp_dec, mem_wr, pc_load, wake;
    logic [15:0] mem_addr, pc_vec;
    logic [7:0]  mem_wdata;
    logic [4:0]  if_ack;

    int checks = 0;
    int errors = 0;

    cpu_irq_dispatcher #(.VEC_BASE(16'h0040), .N_IRQ(5)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .t_phase     (t_phase),
        .instr_bound (instr_bound),
        .halted      (halted),
        .ime         (ime),
        .ie          (ie),
        .if_flags    (if_flags),
        .pc          (pc),
        .sp          (sp),
        .busy        (busy),
        .ime_clr     (ime_clr),
        .sp_dec      (sp_dec),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .pc_load     (pc_load),
        .pc_vec      (pc_vec),
        .if_ack      (if_ack),
        .wake        (wake)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a dispatch is a 20-cycle timeline starting after the accepting T4.
    int          cyc = 0;
    bit          m_act = 0;
    int          m_start = 0;
    int          k;
    logic [15:0] m_vec = 16'h0000;
    logic [15:0] n_vec;
    logic        e_busy, e_imeclr, e_spdec, e_wr, e_pcl, e_wake;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata;
    logic [4:0]  e_ack, mk;

    always @(negedge clk) begin
        cyc++;
        k = cyc - m_start;
        {e_busy, e_imeclr, e_spdec, e_wr, e_pcl, e_wake} = '0;
        e_addr = 16'h0000; e_wdata = 8'h00; e_ack = 5'h00; n_vec = m_vec;
        if (!reset_n) begin
            m_act = 0;
            m_vec = 16'h0000;
            n_vec = 16'h0000;
        end else begin
            e_wake = halted && (|(ie & if_flags));
            if (m_act) begin
                e_busy  = 1'b1;
                e_spdec = (k == 8) || (k == 12);
                e_wr    = (k >= 9) && (k <= 16);
                if (e_wr) begin
                    e_addr  = sp;
                    e_wdata = (k <= 12) ? pc[15:8] : pc[7:0];
                end
                if (k == 16) begin
                    mk = ie & if_flags;
                    n_vec = 16'h0000;
                    for (int i = 4; i >= 0; i--) begin
                        if (mk[i]) begin
                            e_ack = 5'h01 << i;
                            n_vec = 16'h0040 + 16'(8 * i);
                        end
                    end
                    if (mk == 5'h00) e_ack = 5'h00;
                end
                e_pcl = (k == 20);
            end else begin
                e_imeclr = ime && (|(ie & if_flags)) && (instr_bound || halted) && (t_phase == 2'd3);
            end
        end
        chk("busy", busy, e_busy);
        chk("ime_clr", ime_clr, e_imeclr);
        chk("sp_dec", sp_dec, e_spdec);
        chk("mem_wr", mem_wr, e_wr);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("if_ack", if_ack, e_ack);
        chk("pc_load", pc_load, e_pcl);
        chk("pc_vec", pc_vec, m_vec);
        chk("wake", wake, e_wake);
        if (reset_n) begin
            m_vec = n_vec;
            if (m_act && k == 20) m_act = 0;
            if (e_imeclr) begin
                m_act = 1;
                m_start = cyc;
            end
        end
    end

    // Core-side environment: capture outputs mid-cycle, apply their effects after the edge.
    logic [15:0] wr_addr[$];
    logic [7:0]  wr_data[$];
    logic [4:0]  ack_seen;
    int          ack_cnt, busy_cnt, clr_cnt, wr_cnt, ncyc, req_cyc, pcl_cyc;
    bit          pcl_seen;
    logic [15:0] vec_seen;

    task automatic clear_rec();
        wr_addr.delete(); wr_data.delete();
        ack_seen = 5'h00; ack_cnt = 0; busy_cnt = 0; clr_cnt = 0; wr_cnt = 0;
        pcl_seen = 0; vec_seen = 16'h0000; req_cyc = 0; pcl_cyc = 0;
    endtask

    task automatic step();
        logic c_sd, c_wr, c_pl, c_ic;
        logic [15:0] c_addr, c_vec;
        logic [7:0]  c_wd;
        logic [4:0]  c_ack;
        logic [1:0]  c_ph;
        @(negedge clk);
        c_sd = sp_dec; c_wr = mem_wr; c_pl = pc_load; c_ic = ime_clr;
        c_addr = mem_addr; c_vec = pc_vec; c_wd = mem_wdata; c_ack = if_ack; c_ph = t_phase;
        if (busy) busy_cnt++;
        if (c_wr) wr_cnt++;
        if (c_ic) begin clr_cnt++; req_cyc = ncyc; end
        if (c_wr && c_ph == 2'd3) begin wr_addr.push_back(c_addr); wr_data.push_back(c_wd); end
        if (c_ack != 5'h00) begin ack_cnt++; ack_seen = c_ack; end
        if (c_pl) begin pcl_seen = 1; vec_seen = c_vec; pcl_cyc = ncyc; end
        @(posedge clk);
        #1;
        ncyc++;
        t_phase = t_phase + 2'd1;
        if (c_sd) sp = sp - 16'd1;
        if (c_wr && c_ph == 2'd3 && c_addr == 16'hFFFF) ie = c_wd[4:0];
        if (c_ic) ime = 1'b0;
        if_flags = if_flags & ~c_ack;
        if (c_pl) pc = c_vec;
    endtask

    task automatic run_until_load(input string name, input int budget);
        for (int i = 0; i < budget && !pcl_seen; i++) step();
        chk({name, "_load_seen"}, 32'(pcl_seen), 32'd1);
    endtask

    task automatic chk_writes(input string name, input logic [15:0] a0, input logic [7:0] d0,
                              input logic [15:0] a1, input logic [7:0] d1);
        chk({name, "_wr_count"}, 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            chk({name, "_wr0_addr"}, wr_addr[0], a0);
            chk({name, "_wr0_data"}, wr_data[0], d0);
            chk({name, "_wr1_addr"}, wr_addr[1], a1);
            chk({name, "_wr1_data"}, wr_data[1], d1);
        end
    endtask

    initial begin
        clear_rec();
        ncyc = 0;
        repeat (3) step();
        chk("reset_busy", busy, 0);
        chk("reset_pc_vec", pc_vec, 16'h0000);
        reset_n = 1'b1;
        repeat (4) step();

        // 1: timer interrupt, full push and jump
        clear_rec();
        ime = 1; ie = 5'h1F; if_flags = 5'h04; pc = 16'h1234; sp = 16'hD000; instr_bound = 1;
        run_until_load("t1", 40);
        instr_bound = 0;
        chk_writes("t1", 16'hCFFF, 8'h12, 16'hCFFE, 8'h34);
        chk("t1_ack", ack_seen, 5'h04);
        chk("t1_vec", vec_seen, 16'h0050);
        chk("t1_latency", 32'(pcl_cyc - req_cyc), 32'd20);
        chk("t1_sp", sp, 16'hCFFE);
        chk("t1_pc", pc, 16'h0050);
        chk("t1_ime", ime, 0);
        repeat (8) step();

        // 2: only serial+joypad enabled; serial wins
        clear_rec();
        ime = 1; ie = 5'h18; if_flags = 5'h1A; pc = 16'hABCD; sp = 16'hC000; instr_bound = 1;
        run_until_load("t2", 40);
        instr_bound = 0;
        chk_writes("t2", 16'hBFFF, 8'hAB, 16'hBFFE, 8'hCD);
        chk("t2_ack", ack_seen, 5'h08);
        chk("t2_ack_cnt", ack_cnt, 1);
        chk("t2_vec", vec_seen, 16'h0058);
        chk("t2_if_left", if_flags, 5'h12);
        repeat (8) step();

        // 3: PCH push lands on IE at FFFF and clears it -> cancelled dispatch
        clear_rec();
        ime = 1; ie = 5'h01; if_flags = 5'h01; pc = 16'h00AB; sp = 16'h0000; instr_bound = 1;
        run_until_load("t3", 40);
        instr_bound = 0;
        chk_writes("t3", 16'hFFFF, 8'h00, 16'hFFFE, 8'hAB);
        chk("t3_ack_cnt", ack_cnt, 0);
        chk("t3_vec", vec_seen, 16'h0000);
        chk("t3_sp", sp, 16'hFFFE);
        chk("t3_ie", ie, 5'h00);
        chk("t3_if_left", if_flags, 5'h01);
        repeat (8) step();

        // 4: halted with IME clear -> wake only
        clear_rec();
        ime = 0; halted = 1; ie = 5'h01; if_flags = 5'h01;
        #1;
        chk("t4_wake", wake, 1);
        repeat (12) step();
        chk("t4_busy_cnt", busy_cnt, 0);
        chk("t4_clr_cnt", clr_cnt, 0);
        halted = 0;
        #1;
        chk("t4_wake_off", wake, 0);

        // 6: pending but no boundary -> waits for the boundary
        clear_rec();
        ime = 1; ie = 5'h04; if_flags = 5'h04; pc = 16'h2000; sp = 16'hD000; instr_bound = 0;
        repeat (16) step();
        chk("t6_busy_cnt", busy_cnt, 0);
        chk("t6_clr_cnt", clr_cnt, 0);
        instr_bound = 1;
        run_until_load("t6", 40);
        instr_bound = 0;
        chk("t6_vec", vec_seen, 16'h0050);
        chk("t6_latency", 32'(pcl_cyc - req_cyc), 32'd20);
        repeat (8) step();

        // 5: reset during the PCH push
        clear_rec();
        ime = 1; ie = 5'h01; if_flags = 5'h01; pc = 16'h1111; sp = 16'hD000; instr_bound = 1;
        for (int i = 0; i < 40 && wr_cnt == 0; i++) step();
        chk("t5_reached_push", 32'(wr_cnt > 0), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_outs", {busy, ime_clr, sp_dec, mem_wr, pc_load, wake, if_ack},
            {6'b0, 5'h00});
        chk("t5_rst_bus", {mem_addr, mem_wdata}, 32'h0);
        chk("t5_rst_vec", pc_vec, 16'h0000);
        repeat (3) step();
        reset_n = 1'b1;
        clear_rec();
        repeat (30) step();
        chk("t5_no_wr", wr_cnt, 0);
        chk("t5_no_busy", busy_cnt, 0);
        clear_rec();
        ime = 1;
        run_until_load("t5_new", 40);
        instr_bound = 0;
        chk("t5_new_vec", vec_seen, 16'h0040);
        chk("t5_new_ack", ack_seen, 5'h01);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
